// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus: ALU and memory requesters,
// issue strobe, register-file write port and scoreboard.
interface wb_arbiter_if;
  logic        AReq;
  logic [4:0]  AWr;
  logic [31:0] AD;
  logic        AAck;
  logic        MReq;
  logic [4:0]  MWr;
  logic [31:0] MD;
  logic        MAck;
  logic        Iss;
  logic [4:0]  IssR;
  logic        We;
  logic [4:0]  Wr;
  logic [31:0] D;
  logic [31:0] Busy;

  modport slave (
    input  AReq, AWr, AD,
    input  MReq, MWr, MD,
    input  Iss, IssR,
    output AAck, MAck,
    output We, Wr, D, Busy
  );

  modport master (
    output AReq, AWr, AD,
    output MReq, MWr, MD,
    output Iss, IssR,
    input  AAck, MAck,
    input  We, Wr, D, Busy
  );
endinterface

// File: rtl/wb_arbiter.sv
// Two-requester round-robin write-back arbiter with
// registered register-file write port and pending-write scoreboard.
module wb_arbiter (
  input  logic        Clk,
  input  logic        Clrn,
  wb_arbiter_if.slave bus
);
  typedef enum logic {
    LAST_A = 1'b0,
    LAST_M = 1'b1
  } last_e;

  last_e       last_q, last_d;
  logic        we_q, we_d;
  logic [4:0]  wr_q, wr_d;
  logic [31:0] d_q, d_d;
  logic [31:0] busy_q, busy_d;
  logic [31:0] set_v, clr_v;
  logic        gnt_a, gnt_m;

  // Acks are held low while in reset so no transfer is seen.
  always_comb begin
    gnt_a = 1'b0;
    gnt_m = 1'b0;
    if (Clrn) begin
      unique case (1'b1)
        bus.AReq && bus.MReq: begin
          gnt_m = (last_q == LAST_A);
          gnt_a = (last_q == LAST_M);
        end
        bus.AReq && !bus.MReq: gnt_a = 1'b1;
        bus.MReq && !bus.AReq: gnt_m = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    we_d   = 1'b0;
    wr_d   = wr_q;
    d_d    = d_q;
    last_d = last_q;
    if (gnt_a) begin
      we_d   = |bus.AWr;
      wr_d   = bus.AWr;
      d_d    = bus.AD;
      last_d = LAST_A;
    end else if (gnt_m) begin
      we_d   = |bus.MWr;
      wr_d   = bus.MWr;
      d_d    = bus.MD;
      last_d = LAST_M;
    end
  end

  // Set wins over the commit clear; bit 0 never tracks.
  always_comb begin
    set_v = '0;
    clr_v = '0;
    if (bus.Iss) set_v[bus.IssR] = 1'b1;
    if (we_q) clr_v[wr_q] = 1'b1;
    busy_d = ((busy_q & ~clr_v) | set_v)
           & 32'hFFFF_FFFE;
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      last_q <= LAST_A;
      we_q   <= 1'b0;
      wr_q   <= '0;
      d_q    <= '0;
      busy_q <= '0;
    end else begin
      last_q <= last_d;
      we_q   <= we_d;
      wr_q   <= wr_d;
      d_q    <= d_d;
      busy_q <= busy_d;
    end
  end

  assign bus.AAck = gnt_a;
  assign bus.MAck = gnt_m;
  assign bus.We   = we_q;
  assign bus.Wr   = wr_q;
  assign bus.D    = d_q;
  assign bus.Busy = busy_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized scoreboard bench for wb_arbiter with a
// rule-level reference model of grants, writes and pending bits.
module tb_wb_arbiter;
  logic Clk;
  logic Clrn;
  wb_arbiter_if bus();

  wb_arbiter dut (
    .Clk  (Clk),
    .Clrn (Clrn),
    .bus  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [4:0]  wr;
    logic [31:0] d;
    int          c;
  } wr_t;

  wr_t q[$];
  int  n_vec = 0;
  int  n_bad = 0;
  int  cyc = 0;

  logic [31:0] m_busy;
  logic [4:0]  m_wr;
  logic [31:0] m_d;
  logic [4:0]  m_cw;
  logic        m_last_m;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %h want %h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: grant rule, held write port, pending set.
  always @(negedge Clk) begin : model
    logic ga, gm;
    logic [31:0] setv, clrv;
    logic [4:0]  idx;
    logic [31:0] dat;
    if (!Clrn) begin
      chk("rst_we", 32'(bus.We), 0);
      chk("rst_busy", bus.Busy, 0);
      chk("rst_aack", 32'(bus.AAck), 0);
      chk("rst_mack", 32'(bus.MAck), 0);
      q.delete();
      m_busy   = '0;
      m_wr     = '0;
      m_d      = '0;
      m_cw     = '0;
      m_last_m = 1'b0;
    end else begin
      chk("busy", bus.Busy, m_busy);
      chk("wr_hold", 32'(bus.Wr), 32'(m_wr));
      chk("d_hold", bus.D, m_d);
      ga = bus.AReq && (!bus.MReq || m_last_m);
      gm = bus.MReq && !ga;
      chk("aack", 32'(bus.AAck), 32'(ga));
      chk("mack", 32'(bus.MAck), 32'(gm));
      setv = '0;
      clrv = '0;
      if (bus.Iss && bus.IssR != 0)
        setv = 32'd1 << bus.IssR;
      if (m_cw != 0)
        clrv = 32'd1 << m_cw;
      m_busy = (m_busy & ~clrv) | setv;
      m_cw = '0;
      if (ga || gm) begin
        idx      = ga ? bus.AWr : bus.MWr;
        dat      = ga ? bus.AD : bus.MD;
        m_last_m = gm;
        m_wr     = idx;
        m_d      = dat;
        m_cw     = idx;
        if (idx != 0)
          q.push_back('{wr: idx, d: dat, c: cyc});
      end
    end
  end

  // Monitor: every registered write must match the queue head.
  always @(negedge Clk) begin : monitor
    wr_t e;
    if (Clrn) begin
      while (q.size() > 0 && q[0].c < cyc - 1) begin
        n_vec++;
        n_bad++;
        $display("FAIL missing_write got we=0 want wr=%0d",
                 q[0].wr);
        void'(q.pop_front());
      end
      if (bus.We) begin
        if (q.size() > 0 && q[0].c == cyc - 1) begin
          e = q.pop_front();
          chk("we_wr", 32'(bus.Wr), 32'(e.wr));
          chk("we_d", bus.D, e.d);
        end else begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_write got wr=%0d want none",
                   bus.Wr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_in();
    bus.AReq = 1'b0;
    bus.AWr  = '0;
    bus.AD   = '0;
    bus.MReq = 1'b0;
    bus.MWr  = '0;
    bus.MD   = '0;
    bus.Iss  = 1'b0;
    bus.IssR = '0;
  endtask

  task automatic async_chk(input string nm);
    chk({nm, "_we"}, 32'(bus.We), 0);
    chk({nm, "_wr"}, 32'(bus.Wr), 0);
    chk({nm, "_d"}, bus.D, 0);
    chk({nm, "_busy"}, bus.Busy, 0);
    chk({nm, "_aack"}, 32'(bus.AAck), 0);
    chk({nm, "_mack"}, 32'(bus.MAck), 0);
  endtask

  initial begin
    logic at, mt;
    idle_in();
    Clrn = 1'b1;
    #1 Clrn = 1'b0;
    #1 async_chk("por");
    repeat (2) @(posedge Clk);
    #1 Clrn = 1'b1;

    bus.AReq = 1'b1;
    bus.AWr  = 5'd5;
    bus.AD   = 32'h1234_5678;
    tick();
    bus.AReq = 1'b0;
    tick();

    bus.AReq = 1'b1;
    bus.MReq = 1'b1;
    bus.AWr  = 5'd3;
    bus.MWr  = 5'd4;
    bus.AD   = 32'hA0A0_0003;
    bus.MD   = 32'hB0B0_0004;
    repeat (3) tick();
    bus.AReq = 1'b0;
    bus.MReq = 1'b0;
    tick();

    bus.MReq = 1'b1;
    bus.MWr  = 5'd0;
    bus.MD   = 32'hFFFF_FFFF;
    tick();
    bus.MReq = 1'b0;
    tick();

    bus.Iss  = 1'b1;
    bus.IssR = 5'd7;
    tick();
    bus.Iss  = 1'b0;
    bus.AReq = 1'b1;
    bus.AWr  = 5'd7;
    bus.AD   = 32'hC0DE_0007;
    tick();
    bus.AReq = 1'b0;
    bus.Iss  = 1'b1;
    tick();
    bus.Iss  = 1'b1;
    bus.IssR = 5'd0;
    tick();
    bus.Iss  = 1'b0;
    bus.AReq = 1'b1;
    tick();
    bus.AReq = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 1500; i++) begin
      @(negedge Clk);
      at = bus.AAck;
      mt = bus.MAck;
      @(posedge Clk);
      #1;
      if (!bus.AReq || at) begin
        bus.AReq = ($urandom_range(0, 3) != 0);
        bus.AWr  = 5'($urandom_range(0, 31));
        bus.AD   = $urandom;
      end
      if (!bus.MReq || mt) begin
        bus.MReq = ($urandom_range(0, 3) != 0);
        bus.MWr  = 5'($urandom_range(0, 31));
        bus.MD   = $urandom;
      end
      bus.Iss  = ($urandom_range(0, 2) == 0);
      bus.IssR = 5'($urandom_range(0, 31));
    end
    idle_in();
    repeat (2) tick();

    bus.Iss  = 1'b1;
    bus.IssR = 5'd12;
    bus.AReq = 1'b1;
    bus.AWr  = 5'd9;
    bus.AD   = 32'hDEAD_0009;
    tick();
    bus.Iss = 1'b0;
    @(negedge Clk);
    chk("mid_aack", 32'(bus.AAck), 1);
    #2 Clrn = 1'b0;
    #1 async_chk("mid");
    bus.AReq = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Clrn = 1'b1;
    repeat (2) tick();

    bus.AReq = 1'b1;
    bus.MReq = 1'b1;
    bus.AWr  = 5'd10;
    bus.MWr  = 5'd11;
    bus.AD   = 32'h0000_000A;
    bus.MD   = 32'h0000_000B;
    tick();
    idle_in();
    repeat (3) tick();

    chk("q_empty", 32'(q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end
endmodule
